// File: rtl/egr_latency_pkg.sv
// rtl/egr_latency_pkg.sv - field layout, widths and helpers for the egress latency monitor
package egr_latency_pkg;

    localparam int SN_WIDTH         = 32;
    localparam int TS_WIDTH_DEFAULT = 48;

    // egr_cmd tdata layout
    localparam int CMD_PTR_LSB = 0;
    localparam int CMD_CID_LSB = 32;
    localparam int CMD_LEN_LSB = 48;
    localparam int LEN_WIDTH   = 16;

    // snd_una_update tdata layout
    localparam int UNA_CID_LSB = 16;
    localparam int UNA_SN_LSB  = 32;

    typedef struct packed {
        logic [SN_WIDTH-1:0]         sn;
        logic [TS_WIDTH_DEFAULT-1:0] ts;
    } entry_t;

    // ack covers end_sn when the modular distance is non-negative, so wrap is harmless
    function automatic logic sn_covered(input logic [SN_WIDTH-1:0] ack,
                                        input logic [SN_WIDTH-1:0] end_sn);
        logic [SN_WIDTH-1:0] diff;
        diff = ack - end_sn;
        return ~diff[SN_WIDTH-1];
    endfunction

endpackage

// File: rtl/egr_latency_table.sv
// rtl/egr_latency_table.sv - per-cid armed bits, init sweep, entry store and start/stop arbitration
module egr_latency_table #(
    parameter int CID_WIDTH   = 9,
    parameter int ENTRY_WIDTH = 80
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   start_vld_i,
    input  logic [CID_WIDTH-1:0]   start_cid_i,
    input  logic [ENTRY_WIDTH-1:0] start_entry_i,
    input  logic                   stop_clear_i,
    input  logic [CID_WIDTH-1:0]   stop_cid_i,
    output logic                   stop_armed_o,
    output logic [ENTRY_WIDTH-1:0] stop_entry_o,
    output logic                   start_overrun_o,
    output logic                   init_done_o
);

    localparam int DEPTH = 2 ** CID_WIDTH;

    logic [DEPTH-1:0]       valid_q;
    logic [CID_WIDTH-1:0]   sweep_q;
    logic                   init_done_q;
    logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
    logic                   start_accept;

    // A start may reuse an entry that the concurrent stop is retiring
    assign start_accept = start_vld_i &&
                          (!valid_q[start_cid_i] || (stop_clear_i && (stop_cid_i == start_cid_i)));

    assign start_overrun_o = start_vld_i && !start_accept;
    assign stop_armed_o    = valid_q[stop_cid_i];
    assign stop_entry_o    = mem_q[stop_cid_i];
    assign init_done_o     = init_done_q;

    // Sweep pointer walks every cid once after reset, then parks
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            sweep_q     <= '0;
            init_done_q <= 1'b0;
        end else if (!init_done_q) begin
            sweep_q <= sweep_q + 1'b1;
            if (sweep_q == '1) begin
                init_done_q <= 1'b1;
            end
        end
    end

    // Armed bits: cleared by the sweep, then stop clears before start sets
    always_ff @(posedge ap_clk) begin
        if (!init_done_q) begin
            valid_q[sweep_q] <= 1'b0;
        end else if (!ap_rst) begin
            if (stop_clear_i) begin
                valid_q[stop_cid_i] <= 1'b0;
            end
            if (start_accept) begin
                valid_q[start_cid_i] <= 1'b1;
            end
        end
    end

    // Entry store written on the same edge an armed bit is set; read asynchronously
    always_ff @(posedge ap_clk) begin
        if (start_accept && !ap_rst) begin
            mem_q[start_cid_i] <= start_entry_i;
        end
    end

endmodule

// File: rtl/egr_latency.sv
// rtl/egr_latency.sv - passive egress command to snd_una latency monitor
module egr_latency
    import egr_latency_pkg::*;
#(
    parameter int CID_WIDTH = 9,
    parameter int TS_WIDTH  = TS_WIDTH_DEFAULT
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                egr_cmd_tready,
    input  logic                egr_cmd_tvalid,
    input  logic [63:0]         egr_cmd_tdata,
    input  logic                snd_una_update_tready,
    input  logic                snd_una_update_tvalid,
    input  logic [63:0]         snd_una_update_tdata,
    output logic                egr_latency_valid,
    output logic [TS_WIDTH-1:0] egr_latency_data,
    output logic                init_done,
    output logic                err_start_overrun,
    output logic                err_stop_mishit
);

    localparam int EW = SN_WIDTH + TS_WIDTH;

    logic                 cmd_hs, una_hs;
    logic [CID_WIDTH-1:0] cmd_cid, una_cid;
    logic [SN_WIDTH-1:0]  cmd_sn, una_sn;
    logic                 unused_tdata;

    logic [TS_WIDTH-1:0]  ts_q;
    logic                 r_start_vld_q, r_stop_vld_q;
    logic [CID_WIDTH-1:0] r_start_cid_q, r_stop_cid_q;
    logic [SN_WIDTH-1:0]  r_start_sn_q, r_stop_sn_q;
    logic [TS_WIDTH-1:0]  r_start_ts_q, r_stop_ts_q;

    logic                 stop_armed, stop_hit, stop_mishit, start_overrun;
    logic [EW-1:0]        stop_entry;
    logic [SN_WIDTH-1:0]  ent_sn;
    logic [TS_WIDTH-1:0]  ent_ts;
    logic [TS_WIDTH-1:0]  lat_data_d;

    logic                 lat_vld_q, ovr_q, mis_q;
    logic [TS_WIDTH-1:0]  lat_data_q;

    assign cmd_hs  = egr_cmd_tvalid & egr_cmd_tready;
    assign una_hs  = snd_una_update_tvalid & snd_una_update_tready;
    assign cmd_cid = egr_cmd_tdata[CMD_CID_LSB +: CID_WIDTH];
    assign cmd_sn  = egr_cmd_tdata[CMD_PTR_LSB +: SN_WIDTH]
                   + SN_WIDTH'(egr_cmd_tdata[CMD_LEN_LSB +: LEN_WIDTH]);
    assign una_cid = snd_una_update_tdata[UNA_CID_LSB +: CID_WIDTH];
    assign una_sn  = snd_una_update_tdata[UNA_SN_LSB +: SN_WIDTH];

    assign unused_tdata = ^{egr_cmd_tdata[CMD_LEN_LSB-1:CMD_CID_LSB+CID_WIDTH],
                            snd_una_update_tdata[UNA_CID_LSB-1:0],
                            snd_una_update_tdata[UNA_SN_LSB-1:UNA_CID_LSB+CID_WIDTH]};

    // Free-running timestamp
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    // Stage R: capture handshakes once the table is clean
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_start_vld_q <= 1'b0;
            r_start_cid_q <= '0;
            r_start_sn_q  <= '0;
            r_start_ts_q  <= '0;
            r_stop_vld_q  <= 1'b0;
            r_stop_cid_q  <= '0;
            r_stop_sn_q   <= '0;
            r_stop_ts_q   <= '0;
        end else begin
            r_start_vld_q <= cmd_hs & init_done;
            r_start_cid_q <= cmd_cid;
            r_start_sn_q  <= cmd_sn;
            r_start_ts_q  <= ts_q;
            r_stop_vld_q  <= una_hs & init_done;
            r_stop_cid_q  <= una_cid;
            r_stop_sn_q   <= una_sn;
            r_stop_ts_q   <= ts_q;
        end
    end

    egr_latency_table #(
        .CID_WIDTH   (CID_WIDTH),
        .ENTRY_WIDTH (EW)
    ) u_table (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .start_vld_i     (r_start_vld_q),
        .start_cid_i     (r_start_cid_q),
        .start_entry_i   ({r_start_sn_q, r_start_ts_q}),
        .stop_clear_i    (stop_hit),
        .stop_cid_i      (r_stop_cid_q),
        .stop_armed_o    (stop_armed),
        .stop_entry_o    (stop_entry),
        .start_overrun_o (start_overrun),
        .init_done_o     (init_done)
    );

    // Stage E: the stop sees the entry as it stood before this cycle's start
    assign ent_sn      = stop_entry[EW-1 -: SN_WIDTH];
    assign ent_ts      = stop_entry[TS_WIDTH-1:0];
    assign stop_hit    = r_stop_vld_q & stop_armed & sn_covered(r_stop_sn_q, ent_sn);
    assign stop_mishit = r_stop_vld_q & ~stop_armed;
    assign lat_data_d  = r_stop_ts_q - ent_ts;

    // Output registers; latency data holds until the next match
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            lat_vld_q  <= 1'b0;
            lat_data_q <= '0;
            ovr_q      <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            lat_vld_q <= stop_hit;
            ovr_q     <= start_overrun;
            mis_q     <= stop_mishit;
            if (stop_hit) begin
                lat_data_q <= lat_data_d;
            end
        end
    end

    assign egr_latency_valid = lat_vld_q;
    assign egr_latency_data  = lat_data_q;
    assign err_start_overrun = ovr_q;
    assign err_stop_mishit   = mis_q;

endmodule

// File: tb/tb_egr_latency.sv
// tb/tb_egr_latency.sv - randomized self-checking bench for egr_latency
module tb_egr_latency;

    localparam int CW = 9;
    localparam int TW = 48;
    localparam int N  = 2 ** CW;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          egr_cmd_tready, egr_cmd_tvalid;
    logic [63:0]   egr_cmd_tdata;
    logic          snd_una_update_tready, snd_una_update_tvalid;
    logic [63:0]   snd_una_update_tdata;
    logic          egr_latency_valid;
    logic [TW-1:0] egr_latency_data;
    logic          init_done, err_start_overrun, err_stop_mishit;

    always #5 ap_clk = ~ap_clk;

    egr_latency #(.CID_WIDTH(CW), .TS_WIDTH(TW)) dut (
        .ap_clk                (ap_clk),
        .ap_rst                (ap_rst),
        .egr_cmd_tready        (egr_cmd_tready),
        .egr_cmd_tvalid        (egr_cmd_tvalid),
        .egr_cmd_tdata         (egr_cmd_tdata),
        .snd_una_update_tready (snd_una_update_tready),
        .snd_una_update_tvalid (snd_una_update_tvalid),
        .snd_una_update_tdata  (snd_una_update_tdata),
        .egr_latency_valid     (egr_latency_valid),
        .egr_latency_data      (egr_latency_data),
        .init_done             (init_done),
        .err_start_overrun     (err_start_overrun),
        .err_stop_mishit       (err_stop_mishit)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-cid open start record, applied per handshake cycle
    typedef struct packed {
        logic          lv;
        logic [TW-1:0] lat;
        logic          ovr;
        logic          mis;
    } res_t;

    bit            armed [N];
    logic [31:0]   m_sn  [N];
    longint        m_ts  [N];
    longint        cyc = 0;
    int            init_cnt = 0;
    res_t          r_prev = '0;
    res_t          out_exp = '0;
    logic [TW-1:0] held = '0;
    int            pulse_cnt = 0, ovr_cnt = 0, mis_cnt = 0;

    task automatic model_edge();
        res_t        res;
        int          c;
        logic [31:0] sn;
        res = '0;
        if (ap_rst) begin
            foreach (armed[i]) armed[i] = 1'b0;
            init_cnt = 0;
            r_prev   = '0;
            out_exp  = '0;
            held     = '0;
        end else begin
            if (init_cnt >= N) begin
                if (snd_una_update_tvalid && snd_una_update_tready) begin
                    c  = int'(snd_una_update_tdata[16 +: CW]);
                    sn = snd_una_update_tdata[63:32];
                    if (!armed[c]) begin
                        res.mis = 1'b1;
                    end else if ($signed(sn - m_sn[c]) >= 0) begin
                        res.lv   = 1'b1;
                        res.lat  = TW'(cyc - m_ts[c]);
                        armed[c] = 1'b0;
                    end
                end
                if (egr_cmd_tvalid && egr_cmd_tready) begin
                    c = int'(egr_cmd_tdata[32 +: CW]);
                    if (armed[c]) begin
                        res.ovr = 1'b1;
                    end else begin
                        armed[c] = 1'b1;
                        m_sn[c]  = egr_cmd_tdata[31:0] + {16'h0, egr_cmd_tdata[63:48]};
                        m_ts[c]  = cyc;
                    end
                end
            end
            out_exp = r_prev;
            r_prev  = res;
            if (out_exp.lv) held = out_exp.lat;
            if (init_cnt < N) init_cnt++;
        end
        cyc++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge ap_clk);
        @(negedge ap_clk);
        chk("lat_valid", 64'(egr_latency_valid), 64'(out_exp.lv));
        chk("lat_data", 64'(egr_latency_data), 64'(held));
        chk("overrun", 64'(err_start_overrun), 64'(out_exp.ovr));
        chk("mishit", 64'(err_stop_mishit), 64'(out_exp.mis));
        chk("init_done", 64'(init_done), 64'(init_cnt >= N));
        pulse_cnt += int'(egr_latency_valid);
        ovr_cnt   += int'(err_start_overrun);
        mis_cnt   += int'(err_stop_mishit);
    endtask

    task automatic drive(input bit cv, input bit cr, input int ccid, input logic [31:0] ptr,
                         input logic [15:0] len, input bit uv, input bit ur, input int ucid,
                         input logic [31:0] una);
        logic [63:0] c, u;
        c = {$urandom, $urandom};
        u = {$urandom, $urandom};
        c[31:0]     = ptr;
        c[32 +: CW] = CW'(ccid);
        c[63:48]    = len;
        u[16 +: CW] = CW'(ucid);
        u[63:32]    = una;
        egr_cmd_tvalid        = cv;
        egr_cmd_tready        = cr;
        egr_cmd_tdata         = c;
        snd_una_update_tvalid = uv;
        snd_una_update_tready = ur;
        snd_una_update_tdata  = u;
    endtask

    task automatic idle();
        drive(0, 1, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic rand_drive();
        int          cc, uc;
        logic [31:0] ptr, una;
        cc  = int'($urandom_range(0, 7));
        uc  = int'($urandom_range(0, 7));
        ptr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 63))
                                          : 32'($urandom_range(0, 255)) << 4;
        una = armed[uc] ? m_sn[uc] + 32'($urandom_range(0, 16)) - 32'd8 : $urandom;
        drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, cc, ptr,
              16'($urandom_range(0, 64)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, uc, una);
    endtask

    int base_p, base_o, base_m;

    initial begin
        ap_rst = 1'b1;
        idle();
        repeat (3) tick();
        ap_rst = 1'b0;

        // Events during the sweep must be ignored
        for (int i = 0; i < N + 2; i++) begin
            rand_drive();
            tick();
        end
        idle();
        repeat (3) tick();
        chk("init_done_after_sweep", 64'(init_done), 64'd1);

        // Basic match: latency 20
        drive(1, 1, 5, 32'h100, 16'h40, 0, 1, 0, 0);
        tick();
        idle();
        repeat (19) tick();
        drive(0, 1, 0, 0, 0, 1, 1, 5, 32'h140);
        tick();
        idle();
        tick();
        chk("basic_valid", 64'(egr_latency_valid), 64'd1);
        chk("basic_lat", 64'(egr_latency_data), 64'd20);

        // Partial ack then full ack
        base_p = pulse_cnt; base_o = ovr_cnt; base_m = mis_cnt;
        drive(1, 1, 3, 32'h1C0, 16'h40, 0, 1, 0, 0);
        tick();
        idle();
        repeat (3) tick();
        drive(0, 1, 0, 0, 0, 1, 1, 3, 32'h1F0);
        tick();
        idle();
        repeat (7) tick();
        drive(0, 1, 0, 0, 0, 1, 1, 3, 32'h200);
        tick();
        idle();
        tick();
        chk("partial_lat", 64'(egr_latency_data), 64'd12);
        chk("partial_pulses", 64'(pulse_cnt - base_p), 64'd1);
        chk("partial_errs", 64'((ovr_cnt - base_o) + (mis_cnt - base_m)), 64'd0);

        // Wrapped end pointer and overrun; latency from the first start
        base_o = ovr_cnt;
        drive(1, 1, 7, 32'hFFFF_FFF0, 16'h20, 0, 1, 0, 0);
        tick();
        idle();
        repeat (2) tick();
        drive(1, 1, 7, 32'h0, 16'h8, 0, 1, 0, 0);
        tick();
        idle();
        repeat (2) tick();
        drive(0, 1, 0, 0, 0, 1, 1, 7, 32'h10);
        tick();
        idle();
        tick();
        chk("wrap_valid", 64'(egr_latency_valid), 64'd1);
        chk("wrap_lat", 64'(egr_latency_data), 64'd6);
        chk("wrap_overruns", 64'(ovr_cnt - base_o), 64'd1);

        // Same-cycle stop and start on one cid
        drive(1, 1, 9, 32'h1000, 16'h0, 0, 1, 0, 0);
        tick();
        idle();
        repeat (4) tick();
        drive(1, 1, 9, 32'h2000, 16'h10, 1, 1, 9, 32'h1000);
        tick();
        idle();
        tick();
        chk("same_valid", 64'(egr_latency_valid), 64'd1);
        chk("same_lat", 64'(egr_latency_data), 64'd5);
        chk("same_no_ovr", 64'(err_start_overrun), 64'd0);
        drive(0, 1, 0, 0, 0, 1, 1, 9, 32'h2010);
        tick();
        idle();
        tick();
        chk("rearm_valid", 64'(egr_latency_valid), 64'd1);
        chk("rearm_lat", 64'(egr_latency_data), 64'd2);

        // Stop on a never-started cid
        drive(0, 1, 0, 0, 0, 1, 1, 100, 32'h5);
        tick();
        idle();
        tick();
        chk("mishit", 64'(err_stop_mishit), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_drive();
            tick();
        end
        idle();
        repeat (3) tick();

        // Reset one cycle after a matching stop handshake
        base_p = pulse_cnt;
        drive(1, 1, 11, 32'h50, 16'h10, 0, 1, 0, 0);
        tick();
        idle();
        repeat (3) tick();
        drive(0, 1, 0, 0, 0, 1, 1, 11, 32'h60);
        tick();
        idle();
        ap_rst = 1'b1;
        tick();
        tick();
        ap_rst = 1'b0;
        repeat (N + 1) tick();
        chk("rst_no_pulse", 64'(pulse_cnt - base_p), 64'd0);
        drive(0, 1, 0, 0, 0, 1, 1, 11, 32'h60);
        tick();
        idle();
        tick();
        chk("rst_unarmed", 64'(err_stop_mishit), 64'd1);
        chk("rst_unarmed_nolat", 64'(egr_latency_valid), 64'd0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
